// File: rtl/mdio_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_rd_pkg
//  Description : Shared types and constants for the MDIO capture-memory
//                readback controller: FSM state encoding, latency-counter
//                width and the legal read-latency range.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdio_rd_pkg;

   // Legal memory read latency range, in clock cycles
   localparam int c_RD_LAT_MIN = 1;
   localparam int c_RD_LAT_MAX = 4;

   // Counts the WAIT cycles (at most c_RD_LAT_MAX-2 is ever loaded)
   localparam int c_LAT_CNT_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_CAPTURE = 2'd3
   } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/mdio_rd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_rd_mux
//  Description : Registered NUM_MEM:1 selector of DATA_W-bit read lanes.
//                Kept as its own register stage so the wide mux has a full
//                cycle to itself.
//  Ports       : clk, rstn  - clock, async active-low reset
//                i_en       - load the selected lane this cycle
//                i_clr      - synchronous clear (wins over i_en)
//                i_sel      - lane select
//                i_data     - flattened lanes, lane k at [k*DATA_W +: DATA_W]
//                o_data     - registered selected word
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_rd_mux
   import mdio_rd_pkg::*;
#(
   parameter int NUM_MEM = 96,
   parameter int DATA_W  = 9,
   parameter int SEL_W   = 7
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_en,
   input  logic                      i_clr,
   input  logic [SEL_W-1:0]          i_sel,
   input  logic [NUM_MEM*DATA_W-1:0] i_data,
   output logic [DATA_W-1:0]         o_data
);

   logic [DATA_W-1:0] w_lane;
   logic [DATA_W-1:0] r_data;

   always_comb begin
      w_lane = '0;
      for (int i = 0; i < NUM_MEM; i++) begin
         if (i_sel == SEL_W'(i)) begin
            w_lane = i_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_data <= '0;
      end else if (i_clr) begin
         r_data <= '0;
      end else if (i_en) begin
         r_data <= w_lane;
      end
   end

   assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/mdio_mem_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_mem_rd_ctrl
//  Description : MDIO readback controller for the packet-capture memories.
//                Turns a read request into a one-cycle one-hot chip-enable /
//                address strobe, waits RD_LAT cycles and returns the word on
//                a registered data/valid pair. Sticky done flag after the
//                last word of the last memory.
//  Build macro : MDIO_RD_AUTOINC_EN - enables i_rd_inc and the auto-increment
//                pointer; when undefined every read is explicit.
//  Ports       : clk, rstn              - clock, async active-low reset
//                i_mdio_rd_en           - readback enable; low aborts/clears
//                i_rd_req/i_rd_inc      - request, use-pointer select
//                i_rd_sel/i_rd_addr     - explicit memory select / address
//                o_mem_chip_en/o_mem_raddr/i_mem_rdata - memory array side
//                o_rd_data/o_rd_valid   - returned word and its strobe
//                o_rd_busy/o_rd_err/o_rd_done - status
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_mem_rd_ctrl
   import mdio_rd_pkg::*;
#(
   parameter int NUM_MEM   = 96,
   parameter int DATA_W    = 9,
   parameter int ADDR_W    = 15,
   parameter int MEM_DEPTH = 32768,
   parameter int SEL_W     = 7,
   parameter int RD_LAT    = 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_mdio_rd_en,
   input  logic                      i_rd_req,
   input  logic                      i_rd_inc,
   input  logic [SEL_W-1:0]          i_rd_sel,
   input  logic [ADDR_W-1:0]         i_rd_addr,
   output logic [NUM_MEM-1:0]        o_mem_chip_en,
   output logic [NUM_MEM*ADDR_W-1:0] o_mem_raddr,
   input  logic [NUM_MEM*DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0]         o_rd_data,
   output logic                      o_rd_valid,
   output logic                      o_rd_busy,
   output logic                      o_rd_err,
   output logic                      o_rd_done
);

   localparam logic [ADDR_W-1:0]      c_LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [SEL_W-1:0]       c_LAST_SEL  = SEL_W'(NUM_MEM - 1);
   localparam int                     c_WAIT_LOAD = (RD_LAT > 1) ? RD_LAT - 2 : 0;

   generate
      if (RD_LAT < c_RD_LAT_MIN || RD_LAT > c_RD_LAT_MAX) begin : g_rd_lat_bad
         $error("mdio_mem_rd_ctrl: RD_LAT out of range");
      end
   endgenerate

   rd_state_e              r_state;
   rd_state_e              w_next;
   logic [c_LAT_CNT_W-1:0] r_lat_cnt;
   logic [SEL_W-1:0]       r_sel;
   logic [ADDR_W-1:0]      r_addr;
   logic                   r_valid;
   logic                   r_err;
   logic                   r_done;

   logic w_use_ptr;
   logic w_sel_bad;
   logic w_req_ok;
   logic w_accept;
   logic w_capture;
   logic w_last;

`ifdef MDIO_RD_AUTOINC_EN
   logic [SEL_W-1:0]  w_next_sel;
   logic [ADDR_W-1:0] w_next_addr;

   assign w_use_ptr = i_rd_inc;

   // Pointer successor: step the address, carry into the select at the end
   // of a memory, and wrap the whole array back to (0, 0).
   always_comb begin
      w_next_sel  = r_sel;
      w_next_addr = r_addr + 1'b1;
      if (r_addr == c_LAST_ADDR) begin
         w_next_addr = '0;
         w_next_sel  = (r_sel == c_LAST_SEL) ? '0 : r_sel + 1'b1;
      end
   end
`else
   logic w_unused_rd_inc;

   assign w_use_ptr       = 1'b0;
   assign w_unused_rd_inc = i_rd_inc;
`endif

   // Select is compared at 32 bits so NUM_MEM == 2**SEL_W is handled too
   assign w_sel_bad = (32'(i_rd_sel) >= 32'(NUM_MEM));
   // r_valid keeps the block busy for the cycle the word is presented
   assign w_req_ok  = i_mdio_rd_en && i_rd_req && (r_state == ST_IDLE) && !r_valid;
   assign w_accept  = w_req_ok && (w_use_ptr || !w_sel_bad);
   assign w_capture = (r_state == ST_CAPTURE) && i_mdio_rd_en;
   assign w_last    = (r_sel == c_LAST_SEL) && (r_addr == c_LAST_ADDR);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (!i_mdio_rd_en) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (w_accept) w_next = ST_ISSUE;
            ST_ISSUE:   w_next = (RD_LAT == 1) ? ST_CAPTURE : ST_WAIT;
            ST_WAIT:    if (r_lat_cnt == '0) w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
         endcase
      end
   end

   // WAIT lasts RD_LAT-1 cycles: load RD_LAT-2 on ISSUE, leave WAIT at zero
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_lat_cnt <= '0;
      end else if (r_state == ST_ISSUE) begin
         r_lat_cnt <= c_LAT_CNT_W'(c_WAIT_LOAD);
      end else if (r_state == ST_WAIT && r_lat_cnt != '0) begin
         r_lat_cnt <= r_lat_cnt - 1'b1;
      end
   end

   // The request latch doubles as the auto-increment pointer: it advances
   // after each completed read and is left alone by aborts.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sel  <= '0;
         r_addr <= '0;
      end else if (w_accept && !w_use_ptr) begin
         r_sel  <= i_rd_sel;
         r_addr <= i_rd_addr;
      end
`ifdef MDIO_RD_AUTOINC_EN
      else if (w_capture) begin
         r_sel  <= w_next_sel;
         r_addr <= w_next_addr;
      end
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_valid <= w_capture;
         r_err   <= w_req_ok && !w_use_ptr && w_sel_bad;
         if (!i_mdio_rd_en) begin
            r_done <= 1'b0;
         end else if (w_capture && w_last) begin
            r_done <= 1'b1;
         end
      end
   end

   // --------------------------------------------------------- strobes
   generate
      for (genvar g = 0; g < NUM_MEM; g++) begin : g_lane
         logic w_hit;
         assign w_hit                              = (r_state == ST_ISSUE) && (r_sel == SEL_W'(g));
         assign o_mem_chip_en[g]                   = w_hit;
         assign o_mem_raddr[g*ADDR_W +: ADDR_W]    = w_hit ? r_addr : '0;
      end
   endgenerate

   mdio_rd_mux #(
      .NUM_MEM (NUM_MEM),
      .DATA_W  (DATA_W),
      .SEL_W   (SEL_W)
   ) u_mux (
      .clk    (clk),
      .rstn   (rstn),
      .i_en   (w_capture),
      .i_clr  (!i_mdio_rd_en),
      .i_sel  (r_sel),
      .i_data (i_mem_rdata),
      .o_data (o_rd_data)
   );

   assign o_rd_valid = r_valid;
   assign o_rd_busy  = (r_state != ST_IDLE) || r_valid;
   assign o_rd_err   = r_err;
   assign o_rd_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mdio_mem_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_mem_rd_ctrl
//  Description : Directed bench for mdio_mem_rd_ctrl. Two instances share
//                the control inputs: u_dut_a with RD_LAT=1, u_dut_b with
//                RD_LAT=3. Each has its own memory model returning
//                word(lane, addr) = addr[8:0] + 16*lane + 0x32 (mod 512).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_mem_rd_ctrl;

   localparam int NUM_MEM   = 96;
   localparam int DATA_W    = 9;
   localparam int ADDR_W    = 15;
   localparam int MEM_DEPTH = 32768;
   localparam int SEL_W     = 7;

   logic                      clk = 1'b0;
   logic                      rstn;
   logic                      mdio_rd_en;
   logic                      rd_req;
   logic                      rd_inc;
   logic [SEL_W-1:0]          rd_sel;
   logic [ADDR_W-1:0]         rd_addr;

   logic [NUM_MEM-1:0]        ce_a, ce_b;
   logic [NUM_MEM*ADDR_W-1:0] ra_a, ra_b;
   logic [NUM_MEM*DATA_W-1:0] mem_rdata_a = '0;
   logic [NUM_MEM*DATA_W-1:0] mem_b_s1    = '0;
   logic [NUM_MEM*DATA_W-1:0] mem_b_s2    = '0;
   logic [NUM_MEM*DATA_W-1:0] mem_rdata_b = '0;
   logic [DATA_W-1:0]         data_a, data_b;
   logic                      valid_a, valid_b, busy_a, busy_b;
   logic                      err_a, err_b, done_a, done_b;

   int n_vec = 0;
   int n_err = 0;

   logic [NUM_MEM-1:0]        oh;
   logic [NUM_MEM*ADDR_W-1:0] ra_tmp;

   always #5 clk = ~clk;

   mdio_mem_rd_ctrl #(
      .NUM_MEM(NUM_MEM), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .MEM_DEPTH(MEM_DEPTH), .SEL_W(SEL_W), .RD_LAT(1)
   ) u_dut_a (
      .clk(clk), .rstn(rstn), .i_mdio_rd_en(mdio_rd_en), .i_rd_req(rd_req),
      .i_rd_inc(rd_inc), .i_rd_sel(rd_sel), .i_rd_addr(rd_addr),
      .o_mem_chip_en(ce_a), .o_mem_raddr(ra_a), .i_mem_rdata(mem_rdata_a),
      .o_rd_data(data_a), .o_rd_valid(valid_a), .o_rd_busy(busy_a),
      .o_rd_err(err_a), .o_rd_done(done_a)
   );

   mdio_mem_rd_ctrl #(
      .NUM_MEM(NUM_MEM), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .MEM_DEPTH(MEM_DEPTH), .SEL_W(SEL_W), .RD_LAT(3)
   ) u_dut_b (
      .clk(clk), .rstn(rstn), .i_mdio_rd_en(mdio_rd_en), .i_rd_req(rd_req),
      .i_rd_inc(rd_inc), .i_rd_sel(rd_sel), .i_rd_addr(rd_addr),
      .o_mem_chip_en(ce_b), .o_mem_raddr(ra_b), .i_mem_rdata(mem_rdata_b),
      .o_rd_data(data_b), .o_rd_valid(valid_b), .o_rd_busy(busy_b),
      .o_rd_err(err_b), .o_rd_done(done_b)
   );

   // ------------------------------------------------------ memory model
   function automatic logic [DATA_W-1:0] mem_word(input int lane, input logic [ADDR_W-1:0] a);
      return DATA_W'(a) + DATA_W'(lane * 16) + 9'h032;
   endfunction

   // Only strobed lanes return data; all others read 0 so a capture taken
   // in the wrong cycle is visible.
   function automatic logic [NUM_MEM*DATA_W-1:0] mem_resp(input logic [NUM_MEM-1:0] ce,
                                                          input logic [NUM_MEM*ADDR_W-1:0] ra);
      logic [NUM_MEM*DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_MEM; i++) begin
         if (ce[i]) r[i*DATA_W +: DATA_W] = mem_word(i, ra[i*ADDR_W +: ADDR_W]);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      mem_rdata_a <= mem_resp(ce_a, ra_a);
      mem_b_s1    <= mem_resp(ce_b, ra_b);
      mem_b_s2    <= mem_b_s1;
      mem_rdata_b <= mem_b_s2;
   end

   // ------------------------------------------------------------ helpers
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Presents a one-cycle request; returns in cycle 1 of the transaction
   task automatic req(input logic [SEL_W-1:0] s, input logic [ADDR_W-1:0] a, input logic inc);
      rd_req  = 1'b1;
      rd_sel  = s;
      rd_addr = a;
      rd_inc  = inc;
      tick();
      rd_req  = 1'b0;
      rd_inc  = 1'b0;
   endtask

   function automatic logic [NUM_MEM-1:0] onehot(input int k);
      logic [NUM_MEM-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // ------------------------------------------------------------ stimulus
   initial begin
      rstn       = 1'b0;
      mdio_rd_en = 1'b0;
      rd_req     = 1'b0;
      rd_inc     = 1'b0;
      rd_sel     = '0;
      rd_addr    = '0;
      idle(3);

      // Reset state
      chk("rst_ce",    ce_a, '0);
      chk("rst_raddr", |ra_a, 1'b0);
      chk("rst_data",  data_a, '0);
      chk("rst_valid", valid_a, 1'b0);
      chk("rst_busy",  busy_a, 1'b0);
      chk("rst_err",   err_a, 1'b0);
      chk("rst_done",  done_a, 1'b0);

      rstn       = 1'b1;
      mdio_rd_en = 1'b1;
      idle(2);

      // Explicit read (5, 0x123): strobe cycle 1, data 0x1A5 in cycle 3
      req(7'd5, 15'h0123, 1'b0);
      chk("t1_ce_c1", ce_a, onehot(5));
      chk("t1_raddr5_c1", ra_a[5*ADDR_W +: ADDR_W], 15'h0123);
      ra_tmp = ra_a;
      ra_tmp[5*ADDR_W +: ADDR_W] = '0;
      chk("t1_raddr_others_c1", |ra_tmp, 1'b0);
      chk("t1_busy_c1", busy_a, 1'b1);
      chk("t1_valid_c1", valid_a, 1'b0);
      tick();
      chk("t1_ce_c2", ce_a, '0);
      chk("t1_busy_c2", busy_a, 1'b1);
      chk("t1_valid_c2", valid_a, 1'b0);
      tick();
      chk("t1_valid_c3", valid_a, 1'b1);
      chk("t1_data_c3", data_a, 9'h1A5);
      chk("t1_busy_c3", busy_a, 1'b1);
      tick();
      chk("t1_valid_c4", valid_a, 1'b0);
      chk("t1_busy_c4", busy_a, 1'b0);
      chk("t1_data_hold_c4", data_a, 9'h1A5);
      idle(6);

      // Read at the end of memory 7, then a pointer read
      req(7'd7, 15'h7FFF, 1'b0);
      idle(2);
      chk("t2_data_c3", data_a, 9'h0A1);
      idle(6);
`ifdef MDIO_RD_AUTOINC_EN
      req(7'd1, 15'h0042, 1'b1);
      chk("t2_inc_ce_c1", ce_a, onehot(8));
      chk("t2_inc_raddr8_c1", ra_a[8*ADDR_W +: ADDR_W], 15'h0000);
      idle(2);
      chk("t2_inc_data_c3", data_a, 9'h0B2);
`else
      req(7'd2, 15'h0005, 1'b1);
      chk("t2_noinc_ce_c1", ce_a, onehot(2));
      chk("t2_noinc_raddr2_c1", ra_a[2*ADDR_W +: ADDR_W], 15'h0005);
      idle(2);
      chk("t2_noinc_data_c3", data_a, 9'h057);
`endif
      idle(6);

      // Last word of last memory sets sticky done with rd_valid
      req(7'd95, 15'h7FFF, 1'b0);
      chk("t3_ce_c1", ce_a, onehot(95));
      tick();
      chk("t3_done_c2", done_a, 1'b0);
      tick();
      chk("t3_valid_c3", valid_a, 1'b1);
      chk("t3_data_c3", data_a, 9'h021);
      chk("t3_done_c3", done_a, 1'b1);
      idle(3);
      chk("t3_done_sticky", done_a, 1'b1);

      // Bad select: error pulse only
      req(7'd100, 15'h0011, 1'b0);
      chk("t4_err_c1", err_a, 1'b1);
      chk("t4_ce_c1", ce_a, '0);
      chk("t4_busy_c1", busy_a, 1'b0);
      tick();
      chk("t4_err_c2", err_a, 1'b0);
      chk("t4_busy_c2", busy_a, 1'b0);
      chk("t4_valid_c2", valid_a, 1'b0);
      chk("t4_data_hold_c2", data_a, 9'h021);
      chk("t4_done_hold_c2", done_a, 1'b1);

      // Dropping the enable clears done and rd_data
      mdio_rd_en = 1'b0;
      tick();
      chk("t5_done_clr", done_a, 1'b0);
      chk("t5_data_clr", data_a, '0);
      mdio_rd_en = 1'b1;
      idle(3);

      // RD_LAT=3 full read on u_dut_b: data in cycle 5, busy through cycle 5
      req(7'd3, 15'h0010, 1'b0);
      chk("t6_ce_b_c1", ce_b, onehot(3));
      idle(3);
      chk("t6_valid_b_c4", valid_b, 1'b0);
      chk("t6_busy_b_c4", busy_b, 1'b1);
      tick();
      chk("t6_valid_b_c5", valid_b, 1'b1);
      chk("t6_data_b_c5", data_b, 9'h072);
      chk("t6_busy_b_c5", busy_b, 1'b1);
      tick();
      chk("t6_valid_b_c6", valid_b, 1'b0);
      chk("t6_busy_b_c6", busy_b, 1'b0);
      idle(2);

      // Abort during WAIT with a second request while busy
      req(7'd4, 15'h0020, 1'b0);
      chk("t7_ce_b_c1", ce_b, onehot(4));
      rd_req  = 1'b1;
      rd_sel  = 7'd9;
      rd_addr = 15'h0055;
      tick();
      rd_req  = 1'b0;
      chk("t7_ce_b_c2_ignored", ce_b, '0);
      chk("t7_busy_b_c2", busy_b, 1'b1);
      mdio_rd_en = 1'b0;
      tick();
      chk("t7_ce_b_c3", ce_b, '0);
      chk("t7_raddr_b_c3", |ra_b, 1'b0);
      chk("t7_data_b_c3", data_b, '0);
      chk("t7_busy_b_c3", busy_b, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("t7_valid_b_none", valid_b, 1'b0);
         tick();
      end
      mdio_rd_en = 1'b1;
      idle(2);
      chk("t7_busy_b_after", busy_b, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
